// File: rtl/sdram_sched_pkg.sv
// Shared types and widths for the SDRAM burst scheduler and its address generators.
package sdram_sched_pkg;

  localparam int ADDR_W  = 24;
  localparam int BURST_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_REQ   = 3'd1,
    ST_WR_BURST = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_RD_BURST = 3'd4
  } sched_state_e;

endpackage

// File: rtl/sdram_addr_gen.sv
// Per-channel burst address: steps by the burst length at burst end, wraps to the
// region minimum, and defers rewind requests that arrive while a burst is in flight.
module sdram_addr_gen
  import sdram_sched_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AW-1:0]      min_addr,
  input  logic [AW-1:0]      max_addr,
  input  logic [BURST_W-1:0] burst,
  input  logic               load,
  input  logic               busy,
  input  logic               done,
  output logic [AW-1:0]      addr
);

  logic [AW-1:0] addr_q, addr_d;
  logic          pend_q, pend_d;
  logic [AW:0]   sum;

  always_comb begin
    // One extra bit so addr + burst near the top of the space cannot wrap silently.
    sum    = {1'b0, addr_q} + {{(AW + 1 - BURST_W){1'b0}}, burst};
    addr_d = addr_q;
    pend_d = pend_q;
    if (done) begin
      pend_d = 1'b0;
      if (pend_q || load) begin
        addr_d = min_addr;
      end else if (sum >= {1'b0, max_addr}) begin
        addr_d = min_addr;
      end else begin
        addr_d = sum[AW-1:0];
      end
    end else if (load) begin
      if (busy) begin
        pend_d = 1'b1;
      end else begin
        addr_d = min_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= min_addr;
      pend_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      pend_q <= pend_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/sdram_burst_sched.sv
// Arbitrates write-FIFO drain and read-FIFO fill bursts onto one SDRAM controller.
// Handshake: x_req is held until x_ack is seen; ack stays high for the whole burst and its fall ends it.
module sdram_burst_sched
  import sdram_sched_pkg::*;
#(
  parameter int RD_FIFO_DEPTH = 1024,
  parameter int ADDR_W        = sdram_sched_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sdram_init_done,
  input  logic [ADDR_W-1:0]  wr_min_addr,
  input  logic [ADDR_W-1:0]  wr_max_addr,
  input  logic [ADDR_W-1:0]  rd_min_addr,
  input  logic [ADDR_W-1:0]  rd_max_addr,
  input  logic [BURST_W-1:0] wr_burst,
  input  logic [BURST_W-1:0] rd_burst,
  input  logic               wr_load,
  input  logic               rd_load,
  input  logic               rd_en,
  input  logic [10:0]        wr_fifo_cnt,
  input  logic [10:0]        rd_fifo_cnt,
  output logic               sdram_wr_req,
  output logic               sdram_rd_req,
  input  logic               sdram_wr_ack,
  input  logic               sdram_rd_ack,
  output logic [ADDR_W-1:0]  sdram_wr_addr,
  output logic [ADDR_W-1:0]  sdram_rd_addr,
  output logic [BURST_W-1:0] sdram_wr_burst,
  output logic [BURST_W-1:0] sdram_rd_burst,
  output logic [2:0]         dbg_state
);

  sched_state_e       state_q, state_d;
  logic               wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic [BURST_W-1:0] wr_burst_q, wr_burst_d, rd_burst_q, rd_burst_d;
  logic               last_rd_q, last_rd_d;
  logic               wr_elig, rd_elig, wr_done, rd_done, wr_busy, rd_busy;

  assign wr_elig = 32'(wr_fifo_cnt) >= 32'(wr_burst);
  // Written as cnt + burst <= depth so a burst larger than the depth cannot underflow.
  assign rd_elig = rd_en && ((32'(rd_fifo_cnt) + 32'(rd_burst)) <= 32'(RD_FIFO_DEPTH));
  assign wr_busy = (state_q == ST_WR_REQ) || (state_q == ST_WR_BURST);
  assign rd_busy = (state_q == ST_RD_REQ) || (state_q == ST_RD_BURST);

  always_comb begin
    state_d    = state_q;
    wr_req_d   = wr_req_q;
    rd_req_d   = rd_req_q;
    wr_burst_d = wr_burst_q;
    rd_burst_d = rd_burst_q;
    last_rd_d  = last_rd_q;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sdram_init_done) begin
          if (wr_elig && (!rd_elig || last_rd_q)) begin
            state_d    = ST_WR_REQ;
            wr_req_d   = 1'b1;
            wr_burst_d = wr_burst;
          end else if (rd_elig) begin
            state_d    = ST_RD_REQ;
            rd_req_d   = 1'b1;
            rd_burst_d = rd_burst;
          end
        end
      end
      ST_WR_REQ: begin
        if (sdram_wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = ST_WR_BURST;
        end
      end
      ST_WR_BURST: begin
        if (!sdram_wr_ack) begin
          state_d   = ST_IDLE;
          last_rd_d = 1'b0;
          wr_done   = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (sdram_rd_ack) begin
          rd_req_d = 1'b0;
          state_d  = ST_RD_BURST;
        end
      end
      ST_RD_BURST: begin
        if (!sdram_rd_ack) begin
          state_d   = ST_IDLE;
          last_rd_d = 1'b1;
          rd_done   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_burst_q <= '0;
      rd_burst_q <= '0;
      last_rd_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      wr_burst_q <= wr_burst_d;
      rd_burst_q <= rd_burst_d;
      last_rd_q  <= last_rd_d;
    end
  end

  sdram_addr_gen #(.AW(ADDR_W)) u_wr_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .min_addr (wr_min_addr),
    .max_addr (wr_max_addr),
    .burst    (wr_burst_q),
    .load     (wr_load),
    .busy     (wr_busy),
    .done     (wr_done),
    .addr     (sdram_wr_addr)
  );

  sdram_addr_gen #(.AW(ADDR_W)) u_rd_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .min_addr (rd_min_addr),
    .max_addr (rd_max_addr),
    .burst    (rd_burst_q),
    .load     (rd_load),
    .busy     (rd_busy),
    .done     (rd_done),
    .addr     (sdram_rd_addr)
  );

  assign sdram_wr_req   = wr_req_q;
  assign sdram_rd_req   = rd_req_q;
  assign sdram_wr_burst = wr_burst_q;
  assign sdram_rd_burst = rd_burst_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Directed bench for sdram_burst_sched: inputs driven and outputs checked on the falling edge.
module tb_sdram_burst_sched;

  logic        clk = 1'b0;
  logic        rst_n, sdram_init_done;
  logic [23:0] wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr;
  logic [9:0]  wr_burst, rd_burst;
  logic        wr_load, rd_load, rd_en;
  logic [10:0] wr_fifo_cnt, rd_fifo_cnt;
  logic        sdram_wr_req, sdram_rd_req, sdram_wr_ack, sdram_rd_ack;
  logic [23:0] sdram_wr_addr, sdram_rd_addr;
  logic [9:0]  sdram_wr_burst, sdram_rd_burst;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdram_burst_sched #(.RD_FIFO_DEPTH(1024), .ADDR_W(24)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .wr_min_addr     (wr_min_addr),
    .wr_max_addr     (wr_max_addr),
    .rd_min_addr     (rd_min_addr),
    .rd_max_addr     (rd_max_addr),
    .wr_burst        (wr_burst),
    .rd_burst        (rd_burst),
    .wr_load         (wr_load),
    .rd_load         (rd_load),
    .rd_en           (rd_en),
    .wr_fifo_cnt     (wr_fifo_cnt),
    .rd_fifo_cnt     (rd_fifo_cnt),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_wr_addr   (sdram_wr_addr),
    .sdram_rd_addr   (sdram_rd_addr),
    .sdram_wr_burst  (sdram_wr_burst),
    .sdram_rd_burst  (sdram_rd_burst),
    .dbg_state       (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serve one burst as the controller would: wait for req, ack, hold, drop ack.
  task automatic serve(input bit is_wr, input logic [23:0] exp_addr, input bit do_load,
                       input string tag);
    logic req;
    req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      req = is_wr ? sdram_wr_req : sdram_rd_req;
      if (req) break;
      @(negedge clk);
    end
    chk({tag, "_req"}, 32'(req), 32'd1);
    if (!req) return;
    chk({tag, "_other_req"}, 32'(is_wr ? sdram_rd_req : sdram_wr_req), 32'd0);
    chk({tag, "_addr"}, 32'(is_wr ? sdram_wr_addr : sdram_rd_addr), 32'(exp_addr));
    chk({tag, "_burst"}, 32'(is_wr ? sdram_wr_burst : sdram_rd_burst), 32'd512);
    if (is_wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
    @(negedge clk);
    chk({tag, "_req_drop"}, 32'(is_wr ? sdram_wr_req : sdram_rd_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (do_load && k == 0) begin
        if (is_wr) wr_load = 1'b1; else rd_load = 1'b1;
      end
      @(negedge clk);
      wr_load = 1'b0;
      rd_load = 1'b0;
    end
    chk({tag, "_addr_stable"}, 32'(is_wr ? sdram_wr_addr : sdram_rd_addr), 32'(exp_addr));
    if (is_wr) sdram_wr_ack = 1'b0; else sdram_rd_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic got;
    rst_n = 1'b0; sdram_init_done = 1'b0;
    wr_min_addr = 24'h0; wr_max_addr = 24'd1024;
    rd_min_addr = 24'h1000; rd_max_addr = 24'h2000;
    wr_burst = 10'd512; rd_burst = 10'd512;
    wr_load = 1'b0; rd_load = 1'b0; rd_en = 1'b0;
    wr_fifo_cnt = 11'd0; rd_fifo_cnt = 11'd0;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_req", 32'(sdram_wr_req), 32'd0);
    chk("rst_rd_req", 32'(sdram_rd_req), 32'd0);
    chk("rst_wr_addr", 32'(sdram_wr_addr), 32'h0);
    chk("rst_rd_addr", 32'(sdram_rd_addr), 32'h1000);
    chk("rst_wr_burst", 32'(sdram_wr_burst), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Init gating, then first write burst.
    rst_n = 1'b1; wr_fifo_cnt = 11'd600;
    repeat (5) @(negedge clk);
    chk("noinit_wr_req", 32'(sdram_wr_req), 32'd0);
    sdram_init_done = 1'b1;
    @(negedge clk);
    chk("init_wr_req", 32'(sdram_wr_req), 32'd1);
    serve(1'b1, 24'd0, 1'b0, "wr0");
    serve(1'b1, 24'd512, 1'b0, "wr1");
    serve(1'b1, 24'd0, 1'b0, "wr_wrap");

    // Rewind during a burst must override the step (1024 without it).
    wr_max_addr = 24'd2048;
    serve(1'b1, 24'd512, 1'b1, "wr_load_busy");
    serve(1'b1, 24'd0, 1'b0, "wr_after_load");
    wr_fifo_cnt = 11'd0;
    @(negedge clk);
    chk("wr_addr_pre_idle_load", 32'(sdram_wr_addr), 32'd512);
    wr_load = 1'b1;
    @(negedge clk);
    wr_load = 1'b0;
    chk("wr_idle_load", 32'(sdram_wr_addr), 32'd0);

    // Read threshold.
    rd_en = 1'b1; rd_fifo_cnt = 11'd600;
    repeat (4) @(negedge clk);
    chk("rd_600_no_req", 32'(sdram_rd_req), 32'd0);
    rd_fifo_cnt = 11'd513;
    repeat (4) @(negedge clk);
    chk("rd_513_no_req", 32'(sdram_rd_req), 32'd0);
    rd_fifo_cnt = 11'd512;
    serve(1'b0, 24'h1000, 1'b0, "rd0");
    rd_en = 1'b0;

    // Write served last, then both eligible: read first, then alternate.
    wr_fifo_cnt = 11'd600;
    serve(1'b1, 24'd0, 1'b0, "wr_solo");
    rd_en = 1'b1;
    serve(1'b0, 24'h1200, 1'b0, "rr_rd1");
    serve(1'b1, 24'd512, 1'b0, "rr_wr1");
    serve(1'b0, 24'h1400, 1'b0, "rr_rd2");
    serve(1'b1, 24'd1024, 1'b0, "rr_wr2");
    rd_en = 1'b0;

    // Reset in the middle of a write burst.
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      got = sdram_wr_req;
      if (got) break;
      @(negedge clk);
    end
    chk("rstmid_wr_req", 32'(got), 32'd1);
    chk("rstmid_addr", 32'(sdram_wr_addr), 32'd1536);
    sdram_wr_ack = 1'b1;
    @(negedge clk);
    chk("rstmid_in_burst", 32'(dbg_state), 32'd2);
    rst_n = 1'b0; wr_min_addr = 24'h40;
    @(negedge clk);
    chk("rstmid_wr_req_low", 32'(sdram_wr_req), 32'd0);
    chk("rstmid_state_idle", 32'(dbg_state), 32'd0);
    chk("rstmid_addr_min", 32'(sdram_wr_addr), 32'h40);
    chk("rstmid_burst_zero", 32'(sdram_wr_burst), 32'd0);
    rst_n = 1'b1; sdram_wr_ack = 1'b0; wr_fifo_cnt = 11'd0;

    // Stray ack while idle is ignored.
    @(negedge clk);
    sdram_wr_ack = 1'b1;
    @(negedge clk);
    sdram_wr_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_state", 32'(dbg_state), 32'd0);
    chk("stray_ack_addr", 32'(sdram_wr_addr), 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_burst_sched.md
SDRAM_BURST_SCHED -- requirements
Module: sdram_burst_sched

Interface
REQ-001 SHALL have parameter RD_FIFO_DEPTH, default 1024: read-side FIFO capacity in 16-bit words.
REQ-002 SHALL have parameter ADDR_W, default 24: SDRAM word-address width.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clk  input  1: controller clock, the same clock as sdram_controller.
REQ-005 SHALL have port rst_n  input  1: synchronous active-low reset.
REQ-006 SHALL have port sdram_init_done  input  1: SDRAM initialisation complete.
REQ-007 SHALL have port wr_min_addr / wr_max_addr  input  ADDR_W each: write region, max exclusive.
REQ-008 SHALL have port rd_min_addr / rd_max_addr  input  ADDR_W each: read region, max exclusive.
REQ-009 SHALL have port wr_burst / rd_burst  input  10 each: burst length in words, 1..512.
REQ-010 SHALL have port wr_load / rd_load  input  1 each: pulse that rewinds the address to its region minimum.
REQ-011 SHALL have port rd_en  input  1: read channel enabled (display active).
REQ-012 SHALL have port wr_fifo_cnt / rd_fifo_cnt  input  11 each: fill levels of the write and read FIFOs.
REQ-013 SHALL have port sdram_wr_req / sdram_rd_req  output  1 each: burst requests to the SDRAM controller.
REQ-014 SHALL have port sdram_wr_ack / sdram_rd_ack  input  1 each: controller acknowledges, high for the duration of a burst.
REQ-015 SHALL have port sdram_wr_addr / sdram_rd_addr  output  ADDR_W each: burst start addresses.
REQ-016 SHALL have port sdram_wr_burst / sdram_rd_burst  output  10 each: latched burst lengths.

Function
REQ-017 SHALL implement FSM states IDLE, WR_REQ, WR_BURST, RD_REQ and RD_BURST.
REQ-018 SHALL stay in IDLE while sdram_init_done=0.
REQ-019 SHALL treat the write channel as eligible when wr_fifo_cnt >= wr_burst.
REQ-020 SHALL treat the read channel as eligible when rd_en=1 and rd_fifo_cnt <= RD_FIFO_DEPTH - rd_burst.
REQ-021 SHALL, when both channels are eligible in IDLE, grant round-robin: the channel not served last wins, and write wins the first tie after reset.
REQ-022 SHALL move from IDLE to X_REQ on a grant, asserting sdram_x_req on the next clk and latching sdram_x_burst.
REQ-023 SHALL hold sdram_x_req high in X_REQ until sdram_x_ack=1, then deassert it on the next clk and enter X_BURST.
REQ-024 SHALL, in X_BURST, return to IDLE on the first clk where sdram_x_ack=0 (ack falling edge), and record last-served=X.
REQ-025 SHALL update the burst address on that ack falling edge: if addr + burst >= max, then addr := min, else addr := addr + burst.
REQ-026 SHALL perform address arithmetic at ADDR_W+1 bits so no overflow occurs.
REQ-027 SHALL apply an x_load pulse arriving in IDLE to the address on the next clk.
REQ-028 SHALL, for an x_load pulse arriving during X_REQ or X_BURST, set a pending flag and apply it at burst end instead of the increment.
REQ-029 SHALL keep sdram_x_addr and sdram_x_burst stable from request assertion to ack fall.
REQ-030 SHALL never assert sdram_wr_req and sdram_rd_req simultaneously.
REQ-031 SHALL idle the read channel when rd_en falls; any burst already in progress completes first.
REQ-032 SHALL ignore ack pulses received in IDLE.

Reset
REQ-033 SHALL, with rst_n=0 sampled on clk, set state to IDLE, both reqs to 0, addresses to the current region min, burst outputs to 0, pending flags to 0 and last-served to read, effective from the next clk even mid-burst.

Structure
REQ-034 SHALL place the FSM state enum, ADDR_W and the burst width constant in the shared package sdram_sched_pkg.
REQ-035 SHALL implement address stepping, wrap and pending-load handling in one sub-module, sdram_addr_gen, instantiated once per channel.

Verification
REQ-036 SHALL cover: init_done=0 with wr_fifo_cnt=600 -> no req; then init_done=1 -> wr_req rises with addr 0x000000 and burst 512.
REQ-037 SHALL cover: both channels eligible, writes served last -> rd_req granted first, then wr_req, alternating across 4 bursts.
REQ-038 SHALL cover: wr_min=0, wr_max=1024, burst 512 -> addresses 0, 512, 0 (wrap).
REQ-039 SHALL cover: wr_load pulsed mid-WR_BURST at addr 512 -> next burst addr 0, not 1024.
REQ-040 SHALL cover: rd_fifo_cnt=600, depth 1024, rd_burst 512 -> no rd_req; at rd_fifo_cnt=512 -> rd_req asserted.
REQ-041 SHALL cover: rst_n=0 during WR_BURST -> wr_req=0 and state IDLE on the next clk; address reset to wr_min_addr.
